// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execution unit: ARM condition codes
// and NZCV flag bit positions.
package cond_pkg;

    typedef logic [3:0] nzcv_t;
    typedef logic [3:0] cond_t;

    localparam cond_t COND_EQ = 4'h0;
    localparam cond_t COND_NE = 4'h1;
    localparam cond_t COND_CS = 4'h2;
    localparam cond_t COND_CC = 4'h3;
    localparam cond_t COND_MI = 4'h4;
    localparam cond_t COND_PL = 4'h5;
    localparam cond_t COND_VS = 4'h6;
    localparam cond_t COND_VC = 4'h7;
    localparam cond_t COND_HI = 4'h8;
    localparam cond_t COND_LS = 4'h9;
    localparam cond_t COND_GE = 4'hA;
    localparam cond_t COND_LT = 4'hB;
    localparam cond_t COND_GT = 4'hC;
    localparam cond_t COND_LE = 4'hD;
    localparam cond_t COND_AL = 4'hE;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_if.sv
// Control interface between the decoder/datapath (master) and the
// conditional-execution unit (slave), including the gated write enables.
interface cond_if #(
    parameter int CNT_W = 32
);
    import cond_pkg::*;

    cond_t            Cond;
    nzcv_t            ALUFlags;
    logic [1:0]       FlagW;
    logic             PCS;
    logic             NextPC;
    logic             RegW;
    logic             MemW;
    logic             IRWrite;
    logic             CntClr;

    logic             PCWrite;
    logic             RegWrite;
    logic             MemWrite;
    nzcv_t            Flags;
    logic             CondEx;
    logic [CNT_W-1:0] InstrCount;
    logic [CNT_W-1:0] SquashCount;

    modport master (
        output Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW, IRWrite, CntClr,
        input  PCWrite, RegWrite, MemWrite, Flags, CondEx, InstrCount, SquashCount
    );

    modport slave (
        input  Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW, IRWrite, CntClr,
        output PCWrite, RegWrite, MemWrite, Flags, CondEx, InstrCount, SquashCount
    );

endinterface

// File: rtl/cond_check.sv
// Combinational ARM condition-field evaluator against the NZCV flags.
module cond_check
    import cond_pkg::*;
(
    input  cond_t cond,
    input  nzcv_t flags,
    output logic  cond_ok
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        cond_ok = 1'b1;
        case (cond)
            COND_EQ: cond_ok = z;
            COND_NE: cond_ok = ~z;
            COND_CS: cond_ok = c;
            COND_CC: cond_ok = ~c;
            COND_MI: cond_ok = n;
            COND_PL: cond_ok = ~n;
            COND_VS: cond_ok = v;
            COND_VC: cond_ok = ~v;
            COND_HI: cond_ok = c & ~z;
            COND_LS: cond_ok = ~c | z;
            COND_GE: cond_ok = (n == v);
            COND_LT: cond_ok = (n != v);
            COND_GT: cond_ok = ~z & (n == v);
            COND_LE: cond_ok = z | (n != v);
            // AL and the unconditional 4'b1111 space both execute
            default: cond_ok = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution unit: owns NZCV, latches the condition result in the
// decode cycle, gates architectural writes and counts fetched/squashed instrs.
module cond_unit
    import cond_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic   clk,
    input  logic   reset,
    cond_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    nzcv_t            flags_q, flags_d;
    logic             dec_pend_q, dec_pend_d;
    logic             cond_ex_reg_q, cond_ex_reg_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
    logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;

    logic             cond_ok;
    logic             cond_ex;

    cond_check u_cond_check (
        .cond    (bus.Cond),
        .flags   (flags_q),
        .cond_ok (cond_ok)
    );

    always_comb begin
        // In decode the fresh evaluation applies; afterwards the latched one.
        cond_ex       = dec_pend_q ? cond_ok : cond_ex_reg_q;
        dec_pend_d    = bus.IRWrite;
        cond_ex_reg_d = cond_ex_reg_q;
        if (dec_pend_q) begin
            cond_ex_reg_d = cond_ok;
        end

        flags_d = flags_q;
        if (bus.FlagW[1] && cond_ex) begin
            flags_d[FLAG_N:FLAG_Z] = bus.ALUFlags[FLAG_N:FLAG_Z];
        end
        if (bus.FlagW[0] && cond_ex) begin
            flags_d[FLAG_C:FLAG_V] = bus.ALUFlags[FLAG_C:FLAG_V];
        end

        instr_cnt_d = instr_cnt_q;
        if (bus.CntClr) begin
            instr_cnt_d = '0;
        end else if (bus.IRWrite) begin
            instr_cnt_d = instr_cnt_q + CNT_ONE;
        end

        squash_cnt_d = squash_cnt_q;
        if (bus.CntClr) begin
            squash_cnt_d = '0;
        end else if (dec_pend_q && !cond_ok) begin
            squash_cnt_d = squash_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q       <= '0;
            dec_pend_q    <= 1'b0;
            cond_ex_reg_q <= 1'b0;
            instr_cnt_q   <= '0;
            squash_cnt_q  <= '0;
        end else begin
            flags_q       <= flags_d;
            dec_pend_q    <= dec_pend_d;
            cond_ex_reg_q <= cond_ex_reg_d;
            instr_cnt_q   <= instr_cnt_d;
            squash_cnt_q  <= squash_cnt_d;
        end
    end

    assign bus.PCWrite     = bus.NextPC | (bus.PCS & cond_ex);
    assign bus.RegWrite    = bus.RegW & cond_ex;
    assign bus.MemWrite    = bus.MemW & cond_ex;
    assign bus.Flags       = flags_q;
    assign bus.CondEx      = cond_ex;
    assign bus.InstrCount  = instr_cnt_q;
    assign bus.SquashCount = squash_cnt_q;

endmodule
